// File: rtl/sandik_kilit.sv
// Sequential combination lock: digit-by-digit code entry, open state, timed lockout after MAX_TRIES wrong codes.
// Optional in-field code reprogramming while open is enabled by defining SANDIK_PROG_EN.
module sandik_kilit #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0] CODE = 16'h1234,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  localparam int CW = $clog2(CODE_LEN+1),
  localparam int TW = $clog2(MAX_TRIES+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] D,
  input  logic               V,
  input  logic               C,
  input  logic               P,
  output logic               S,
  output logic               L,
  output logic               E,
  output logic [CW-1:0]      CNT,
  output logic [TW-1:0]      TRY
);
  localparam int CODE_W = DIGIT_W*CODE_LEN;
  localparam int MW     = $clog2(LOCK_CYCLES+1);
  localparam logic [CW-1:0] LAST     = CW'(CODE_LEN-1);
  localparam logic [TW-1:0] TRY_LIM  = TW'(MAX_TRIES);
  localparam logic [MW-1:0] TMR_LOAD = MW'(LOCK_CYCLES-1);

  typedef enum logic [1:0] {ENTER, OPEN, LOCKOUT} state_t;

  state_t              state;
  logic [MW-1:0]       timer;
  logic                mis;
  logic [DIGIT_W-1:0]  exp_digit;
  logic                wrong;
  logic [TW-1:0]       try_inc;

`ifdef SANDIK_PROG_EN
  logic [CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]   new_code;
  logic [CODE_W-1:0]   shifted;
  assign shifted = (new_code << DIGIT_W) | CODE_W'(D);
`else
  logic [CODE_W-1:0]   code_q;
  logic                unused_p;
  assign code_q   = CODE;
  assign unused_p = P;
`endif

  // Digit 0 of the code lives in the MSBs.
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (int'(CNT) == i) exp_digit = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  assign wrong   = mis | (D != exp_digit);
  assign try_inc = TRY + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ENTER;
      S     <= 1'b0;
      L     <= 1'b0;
      E     <= 1'b0;
      CNT   <= '0;
      TRY   <= '0;
      timer <= '0;
      mis   <= 1'b0;
`ifdef SANDIK_PROG_EN
      code_q   <= CODE;
      new_code <= '0;
`endif
    end else begin
      E <= 1'b0;
      case (state)
        ENTER: begin
          if (C) begin
            CNT <= '0;
            mis <= 1'b0;
          end else if (V) begin
            if (CNT == LAST) begin
              CNT <= '0;
              mis <= 1'b0;
              if (!wrong) begin
                state <= OPEN;
                S     <= 1'b1;
                TRY   <= '0;
              end else begin
                E <= 1'b1;
                if (try_inc == TRY_LIM) begin
                  state <= LOCKOUT;
                  L     <= 1'b1;
                  TRY   <= '0;
                  timer <= TMR_LOAD;
                end else begin
                  TRY <= try_inc;
                end
              end
            end else begin
              CNT <= CNT + 1'b1;
              mis <= wrong;
            end
          end
        end
        OPEN: begin
          if (C) begin
            state <= ENTER;
            S     <= 1'b0;
            CNT   <= '0;
          end
`ifdef SANDIK_PROG_EN
          // Dropping P mid-sequence abandons the partially entered new code.
          else if (!P) begin
            CNT <= '0;
          end else if (V) begin
            if (CNT == LAST) begin
              code_q <= shifted;
              CNT    <= '0;
            end else begin
              new_code <= shifted;
              CNT      <= CNT + 1'b1;
            end
          end
`endif
        end
        LOCKOUT: begin
          if (timer == '0) begin
            state <= ENTER;
            L     <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= ENTER;
      endcase
    end
  end
endmodule

// File: tb/tb_sandik_kilit.sv
// Directed bench for sandik_kilit with default parameters; inputs change and outputs are sampled on the falling edge.
// Define SANDIK_PROG_EN for both files to include the reprogramming scenario.
module tb_sandik_kilit;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D;
  logic       V, C, P;
  logic       S, L, E;
  logic [2:0] CNT;
  logic [1:0] TRY;

  int n_chk = 0;
  int n_fail = 0;
  int e_seen = 0;
  int e0;
  int lock_len;

  sandik_kilit dut (
    .clk(clk), .rst(rst), .D(D), .V(V), .C(C), .P(P),
    .S(S), .L(L), .E(E), .CNT(CNT), .TRY(TRY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one rising edge; return at the following falling edge with inputs idle.
  task automatic cyc(input logic v, input logic [3:0] d, input logic c, input logic p);
    V = v; D = d; C = c; P = p;
    @(posedge clk);
    @(negedge clk);
    e_seen += int'(E);
    V = 1'b0; D = 4'd0; C = 1'b0; P = 1'b0;
  endtask

  task automatic code4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    cyc(1'b1, a, 1'b0, 1'b0);
    cyc(1'b1, b, 1'b0, 1'b0);
    cyc(1'b1, c, 1'b0, 1'b0);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic close_safe();
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    check("close_s", int'(S), 0);
  endtask

  initial begin
    rst = 1'b1; V = 1'b0; D = 4'd0; C = 1'b0; P = 1'b0;
    @(negedge clk);
    check("rst_s", int'(S), 0);
    check("rst_l", int'(L), 0);
    check("rst_e", int'(E), 0);
    check("rst_cnt", int'(CNT), 0);
    check("rst_try", int'(TRY), 0);
    @(negedge clk);
    rst = 1'b0;

    // correct code opens on the cycle after the 4th strobe
    e0 = e_seen;
    cyc(1'b1, 4'd1, 1'b0, 1'b0); check("cnt1", int'(CNT), 1);
    cyc(1'b1, 4'd2, 1'b0, 1'b0); check("cnt2", int'(CNT), 2);
    cyc(1'b1, 4'd3, 1'b0, 1'b0); check("cnt3", int'(CNT), 3); check("s_before_last", int'(S), 0);
    cyc(1'b1, 4'd4, 1'b0, 1'b0);
    check("open_s", int'(S), 1);
    check("open_cnt", int'(CNT), 0);
    check("open_try", int'(TRY), 0);
    check("open_no_e", e_seen - e0, 0);
    cyc(1'b1, 4'd7, 1'b0, 1'b0);
    check("open_ignores_v_s", int'(S), 1);
    check("open_ignores_v_cnt", int'(CNT), 0);
    close_safe();

    // one wrong code, then the right one
    code4(4'd1, 4'd2, 4'd3, 4'd5);
    check("wrong_e", int'(E), 1);
    check("wrong_s", int'(S), 0);
    check("wrong_try", int'(TRY), 1);
    check("wrong_cnt", int'(CNT), 0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    check("e_one_cycle", int'(E), 0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    check("retry_s", int'(S), 1);
    check("retry_try", int'(TRY), 0);
    close_safe();

    // three wrong codes -> lockout of 16 cycles, strobes ignored
    code4(4'd5, 4'd5, 4'd5, 4'd5);
    code4(4'd5, 4'd5, 4'd5, 4'd5);
    check("try2", int'(TRY), 2);
    code4(4'd5, 4'd5, 4'd5, 4'd5);
    check("lock_l", int'(L), 1);
    check("lock_e", int'(E), 1);
    check("lock_try", int'(TRY), 0);
    check("lock_s", int'(S), 0);
    lock_len = 1;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 4'(i % 5), 1'b0, 1'b0);
      if (L) lock_len++;
      else break;
    end
    check("lock_len", lock_len, 16);
    check("post_lock_cnt", int'(CNT), 0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    check("post_lock_open", int'(S), 1);
    close_safe();

    // C aborts entry, clears mismatch flag, and wins over V
    e0 = e_seen;
    cyc(1'b1, 4'd9, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    cyc(1'b1, 4'd1, 1'b0, 1'b0);
    cyc(1'b1, 4'd2, 1'b0, 1'b0);
    check("abort_pre_cnt", int'(CNT), 2);
    cyc(1'b1, 4'd3, 1'b1, 1'b0);
    check("abort_cnt", int'(CNT), 0);
    check("abort_try", int'(TRY), 0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    check("abort_then_open", int'(S), 1);
    check("abort_no_e", e_seen - e0, 0);
    close_safe();

    // async reset mid-entry
    cyc(1'b1, 4'd1, 1'b0, 1'b0);
    cyc(1'b1, 4'd2, 1'b0, 1'b0);
    check("mid_cnt", int'(CNT), 2);
    #2 rst = 1'b1;
    #1 check("arst_entry_cnt", int'(CNT), 0);
    check("arst_entry_s", int'(S), 0);
    @(negedge clk);
    rst = 1'b0;
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    check("arst_entry_open", int'(S), 1);
    close_safe();

    // async reset mid-lockout
    code4(4'd5, 4'd5, 4'd5, 4'd5);
    code4(4'd5, 4'd5, 4'd5, 4'd5);
    code4(4'd5, 4'd5, 4'd5, 4'd5);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    check("mid_lock_l", int'(L), 1);
    #2 rst = 1'b1;
    #1 check("arst_lock_l", int'(L), 0);
    check("arst_lock_try", int'(TRY), 0);
    check("arst_lock_e", int'(E), 0);
    @(negedge clk);
    rst = 1'b0;
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    check("arst_lock_open", int'(S), 1);
    close_safe();

`ifdef SANDIK_PROG_EN
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    cyc(1'b1, 4'd9, 1'b0, 1'b1);
    cyc(1'b1, 4'd8, 1'b0, 1'b1);
    cyc(1'b1, 4'd7, 1'b0, 1'b1);
    check("prog_cnt", int'(CNT), 3);
    cyc(1'b1, 4'd6, 1'b0, 1'b1);
    check("prog_done_cnt", int'(CNT), 0);
    check("prog_still_open", int'(S), 1);
    close_safe();
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    check("prog_old_code_e", int'(E), 1);
    code4(4'd9, 4'd8, 4'd7, 4'd6);
    check("prog_new_code_s", int'(S), 1);
    close_safe();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
